dtl_gm_responder: RTL and testbench
===================================

Name: dtl_gm_responder

Overview:
- DTL slave that terminates the CGRA global-memory DTL master port (DMEM side) and drives a single-port synchronous SRAM.
- Serves single-word and block read/write commands and handles read back-pressure with a 2-entry skid buffer.
- Used in simulation and FPGA builds wherever the non-native global-memory interface is selected, so the core sees a real DTL target.

Parameters:
- INTERFACE_WIDTH, 32, DTL data width; byte enables = INTERFACE_WIDTH/8.
- INTERFACE_ADDR_WIDTH, 32, DTL byte address width.
- INTERFACE_BLOCK_WIDTH, 5, BlockSize width; a burst is BlockSize+1 beats.
- MEM_ADDR_WIDTH, 10, SRAM word address width.

Ports:
- iClk  in  1  clock; all state changes on its rising edge.
- iReset  in  1  synchronous reset, active-high.
- iDTL_CommandValid  in  1  command valid.
- oDTL_CommandAccept  out  1  command accepted.
- iDTL_CommandReadWrite  in  1  1=read, 0=write.
- iDTL_Address  in  INTERFACE_ADDR_WIDTH  byte address; bits [1:0] ignored.
- iDTL_BlockSize  in  INTERFACE_BLOCK_WIDTH  beats minus 1.
- iDTL_WriteValid  in  1  write beat valid.
- oDTL_WriteAccept  out  1  write beat accepted.
- iDTL_WriteData  in  INTERFACE_WIDTH  write data.
- iDTL_WriteEnable  in  INTERFACE_WIDTH/8  byte enables.
- iDTL_WriteLast  in  1  last write beat marker.
- oDTL_ReadValid  out  1  read beat valid.
- iDTL_ReadAccept  in  1  read beat consumed.
- oDTL_ReadData  out  INTERFACE_WIDTH  read data.
- oDTL_ReadLast  out  1  last read beat marker.
- oMem_Address  out  MEM_ADDR_WIDTH  SRAM word address.
- oMem_WriteEnable  out  INTERFACE_WIDTH/8  SRAM byte write strobes.
- oMem_WriteData  out  INTERFACE_WIDTH  SRAM write data.
- oMem_ReadEnable  out  1  SRAM read strobe; data valid on iMem_ReadData exactly 1 cycle later.
- iMem_ReadData  in  INTERFACE_WIDTH  SRAM read data.
- oProtocolError  out  1  sticky error flag.

Behaviour:
- Reset: state=IDLE, all counters, skid-buffer entries and in-flight flag cleared, oProtocolError=0. Every output is 0 during and after reset, except oDTL_CommandAccept, which is 1 from the first cycle after reset.
- Reset mid-burst aborts the burst immediately. No further memory strobes are issued. A read returning in the cycle reset is asserted is discarded.
- States: IDLE, WRITE, READ.
  - oDTL_CommandAccept = (state==IDLE), driven combinationally from state.
  - On CommandValid&&CommandAccept: latch word address = Address[MEM_ADDR_WIDTH+1:2], latch BlockSize, clear beat counter. Next state is READ if CommandReadWrite=1, otherwise WRITE.
- WRITE:
  - oDTL_WriteAccept=1.
  - Each beat with WriteValid: oMem_Address=base+count (mod 2^MEM_ADDR_WIDTH), oMem_WriteData=WriteData, oMem_WriteEnable=WriteEnable, all in the same cycle. count increments.
  - oMem_WriteEnable=0 whenever no beat is accepted.
  - The beat with count==BlockSize returns the state to IDLE.
  - If WriteLast disagrees with (count==BlockSize) on any accepted beat, set oProtocolError. Termination is always governed by the count.
- READ:
  - A read issues (oMem_ReadEnable=1, oMem_Address=base+issued) when issued<=BlockSize and (buffer occupancy + in-flight) < 2, counting a same-cycle pop as freeing a slot.
  - Returned data enters the 2-entry FIFO in the cycle after issue, tagged last = (its beat index == BlockSize).
  - oDTL_ReadValid = FIFO non-empty. ReadData and ReadLast come from the FIFO head. A pop occurs on ReadValid&&ReadAccept.
  - The state returns to IDLE in the cycle the last beat is popped. CommandAccept is high in the following cycle.
  - With ReadAccept held high, steady state is 1 beat/cycle. First-beat latency is 2 cycles after command accept: the command is accepted in cycle t, the read issues in t+1, ReadValid is high in t+2.
- Address wrap: the word address wraps modulo 2^MEM_ADDR_WIDTH. No error is flagged for wrap.
- CommandValid outside IDLE is ignored (not accepted). oMem_ReadEnable and oMem_WriteEnable are never both active.
- oProtocolError is cleared only by reset.

Test Plan:
- Single write then read: write addr 0x10, BlockSize 0, data 0xDEADBEEF, WE 0xF → SRAM word 4 = 0xDEADBEEF. Read addr 0x10 → ReadValid in cycle t+2 with 0xDEADBEEF and ReadLast=1.
- Byte enables: preload word 4 = 0x11223344, write 0xAABBCCDD with WE 0x5 → read returns 0x11BB33DD.
- Read burst with back-pressure: BlockSize 3 at word 0 (data 0,1,2,3); ReadAccept toggles 1,0,0,1,1,0,1 → beats delivered in order 0..3, no loss or duplication, ReadLast only on beat 3, never more than 2 reads outstanding.
- Wrap: MEM_ADDR_WIDTH=10, write burst BlockSize 2 at byte addr 0xFF8 → SRAM words 1022, 1023, 0 written.
- Protocol error: 4-beat write with WriteLast on beat 2 → all 4 beats written, return to IDLE after beat 4, oProtocolError=1 until reset.
- Reset mid read burst: assert iReset on beat 1 of 4 → next cycle ReadValid=0, CommandAccept=1, no mem strobes, a new write command completes normally.

Source files
------------

// File: rtl/dtl_gm_responder.sv
// DTL slave terminating the global-memory master port onto a single-port synchronous SRAM.
// Supports single and block reads/writes; reads pass through a 2-entry fall-through skid buffer.
module dtl_gm_responder #(
    parameter int unsigned INTERFACE_WIDTH       = 32,
    parameter int unsigned INTERFACE_ADDR_WIDTH  = 32,
    parameter int unsigned INTERFACE_BLOCK_WIDTH = 5,
    parameter int unsigned MEM_ADDR_WIDTH        = 10
) (
    input  logic                             iClk,
    input  logic                             iReset,
    input  logic                             iDTL_CommandValid,
    output logic                             oDTL_CommandAccept,
    input  logic                             iDTL_CommandReadWrite,
    input  logic [INTERFACE_ADDR_WIDTH-1:0]  iDTL_Address,
    input  logic [INTERFACE_BLOCK_WIDTH-1:0] iDTL_BlockSize,
    input  logic                             iDTL_WriteValid,
    output logic                             oDTL_WriteAccept,
    input  logic [INTERFACE_WIDTH-1:0]       iDTL_WriteData,
    input  logic [INTERFACE_WIDTH/8-1:0]     iDTL_WriteEnable,
    input  logic                             iDTL_WriteLast,
    output logic                             oDTL_ReadValid,
    input  logic                             iDTL_ReadAccept,
    output logic [INTERFACE_WIDTH-1:0]       oDTL_ReadData,
    output logic                             oDTL_ReadLast,
    output logic [MEM_ADDR_WIDTH-1:0]        oMem_Address,
    output logic [INTERFACE_WIDTH/8-1:0]     oMem_WriteEnable,
    output logic [INTERFACE_WIDTH-1:0]       oMem_WriteData,
    output logic                             oMem_ReadEnable,
    input  logic [INTERFACE_WIDTH-1:0]       iMem_ReadData,
    output logic                             oProtocolError
);
    localparam int unsigned CntW = INTERFACE_BLOCK_WIDTH + 1;

    typedef enum logic [1:0] {StIdle, StWrite, StRead} stateT;

    stateT                            stateQ, stateD;
    logic [MEM_ADDR_WIDTH-1:0]        baseQ;
    logic [INTERFACE_BLOCK_WIDTH-1:0] blockSizeQ;
    logic [CntW-1:0]                  countQ, countD;
    logic                             inFlightQ, inFlightLastQ;
    logic [INTERFACE_WIDTH-1:0]       fifoDataQ [2];
    logic [1:0]                       fifoLastQ;
    logic                             rdPtrQ, wrPtrQ;
    logic [1:0]                       occQ;
    logic                             errQ;

    logic                             cmdAccept, cmdFire, writeBeat, isLastCount;
    logic                             headValid, headLast, pop, bypass, push, issue;
    logic [INTERFACE_WIDTH-1:0]       headData;
    logic [2:0]                       pending;
    logic                             unusedAddr;

    assign unusedAddr = ^iDTL_Address;

    always_comb begin
        cmdAccept   = (stateQ == StIdle) && !iReset;
        cmdFire     = cmdAccept && iDTL_CommandValid;
        isLastCount = (countQ == CntW'(blockSizeQ));
        writeBeat   = (stateQ == StWrite) && iDTL_WriteValid && !iReset;
        // Fall-through: a returning SRAM word is presented directly when the buffer is empty.
        headValid   = (occQ != 2'd0) || inFlightQ;
        headData    = (occQ != 2'd0) ? fifoDataQ[rdPtrQ] : iMem_ReadData;
        headLast    = (occQ != 2'd0) ? fifoLastQ[rdPtrQ] : inFlightLastQ;
        pop         = headValid && iDTL_ReadAccept && !iReset;
        bypass      = (occQ == 2'd0) && inFlightQ && pop;
        push        = inFlightQ && !bypass;
        pending     = 3'(occQ) + 3'(inFlightQ) - 3'(pop);
        issue       = (stateQ == StRead) && (countQ <= CntW'(blockSizeQ)) &&
                      (pending < 3'd2) && !iReset;
    end

    always_comb begin
        stateD = stateQ;
        countD = countQ;
        case (stateQ)
            StIdle: begin
                if (cmdFire) begin
                    stateD = iDTL_CommandReadWrite ? StRead : StWrite;
                    countD = '0;
                end
            end
            StWrite: begin
                if (writeBeat) begin
                    countD = countQ + 1'b1;
                    if (isLastCount) stateD = StIdle;
                end
            end
            StRead: begin
                if (issue) countD = countQ + 1'b1;
                if (pop && headLast) stateD = StIdle;
            end
            default: stateD = StIdle;
        endcase
    end

    always_comb begin
        oDTL_CommandAccept = cmdAccept;
        oDTL_WriteAccept   = (stateQ == StWrite) && !iReset;
        oDTL_ReadValid     = headValid && !iReset;
        oDTL_ReadData      = (headValid && !iReset) ? headData : '0;
        oDTL_ReadLast      = headValid && !iReset && headLast;
        oMem_Address       = (writeBeat || issue) ? baseQ + MEM_ADDR_WIDTH'(countQ) : '0;
        oMem_WriteEnable   = writeBeat ? iDTL_WriteEnable : '0;
        oMem_WriteData     = writeBeat ? iDTL_WriteData : '0;
        oMem_ReadEnable    = issue;
        oProtocolError     = errQ && !iReset;
    end

    always_ff @(posedge iClk) begin
        if (iReset) begin
            stateQ        <= StIdle;
            baseQ         <= '0;
            blockSizeQ    <= '0;
            countQ        <= '0;
            inFlightQ     <= 1'b0;
            inFlightLastQ <= 1'b0;
            fifoDataQ[0]  <= '0;
            fifoDataQ[1]  <= '0;
            fifoLastQ     <= '0;
            rdPtrQ        <= 1'b0;
            wrPtrQ        <= 1'b0;
            occQ          <= '0;
            errQ          <= 1'b0;
        end else begin
            stateQ    <= stateD;
            countQ    <= countD;
            inFlightQ <= issue;
            if (cmdFire) begin
                baseQ      <= iDTL_Address[MEM_ADDR_WIDTH+1:2];
                blockSizeQ <= iDTL_BlockSize;
            end
            if (issue) inFlightLastQ <= isLastCount;
            if (push) begin
                fifoDataQ[wrPtrQ] <= iMem_ReadData;
                fifoLastQ[wrPtrQ] <= inFlightLastQ;
                wrPtrQ            <= ~wrPtrQ;
            end
            if (pop && !bypass) rdPtrQ <= ~rdPtrQ;
            occQ <= occQ + 2'(push) - 2'(pop && !bypass);
            // Beat count decides termination; a misplaced WriteLast is only recorded.
            if (writeBeat && (iDTL_WriteLast != isLastCount)) errQ <= 1'b1;
        end
    end
endmodule

// File: tb/tb_dtl_gm_responder.sv
// Directed self-checking bench for dtl_gm_responder with a byte-enabled 1-cycle-latency SRAM model.
module tb_dtl_gm_responder;
    logic        iClk = 1'b0;
    logic        iReset;
    logic        iDTL_CommandValid, oDTL_CommandAccept, iDTL_CommandReadWrite;
    logic [31:0] iDTL_Address;
    logic [4:0]  iDTL_BlockSize;
    logic        iDTL_WriteValid, oDTL_WriteAccept, iDTL_WriteLast;
    logic [31:0] iDTL_WriteData;
    logic [3:0]  iDTL_WriteEnable;
    logic        oDTL_ReadValid, iDTL_ReadAccept, oDTL_ReadLast;
    logic [31:0] oDTL_ReadData;
    logic [9:0]  oMem_Address;
    logic [3:0]  oMem_WriteEnable;
    logic [31:0] oMem_WriteData;
    logic        oMem_ReadEnable;
    logic [31:0] iMem_ReadData;
    logic        oProtocolError;

    logic [31:0] mem [1024];
    logic [31:0] wrBeats [16];
    logic [31:0] rdGot [16];
    logic [15:0] rdLastGot;
    int          nGot, firstValid;
    int          errCount = 0;
    int          checkCount = 0;
    int          outst = 0;
    int          maxOut = 0;
    int          bothCnt = 0;
    int          rstStrobeCnt = 0;
    int          idleStrobes;

    always #5 iClk = ~iClk;

    dtl_gm_responder dut (
        .iClk                 (iClk),
        .iReset               (iReset),
        .iDTL_CommandValid    (iDTL_CommandValid),
        .oDTL_CommandAccept   (oDTL_CommandAccept),
        .iDTL_CommandReadWrite(iDTL_CommandReadWrite),
        .iDTL_Address         (iDTL_Address),
        .iDTL_BlockSize       (iDTL_BlockSize),
        .iDTL_WriteValid      (iDTL_WriteValid),
        .oDTL_WriteAccept     (oDTL_WriteAccept),
        .iDTL_WriteData       (iDTL_WriteData),
        .iDTL_WriteEnable     (iDTL_WriteEnable),
        .iDTL_WriteLast       (iDTL_WriteLast),
        .oDTL_ReadValid       (oDTL_ReadValid),
        .iDTL_ReadAccept      (iDTL_ReadAccept),
        .oDTL_ReadData        (oDTL_ReadData),
        .oDTL_ReadLast        (oDTL_ReadLast),
        .oMem_Address         (oMem_Address),
        .oMem_WriteEnable     (oMem_WriteEnable),
        .oMem_WriteData       (oMem_WriteData),
        .oMem_ReadEnable      (oMem_ReadEnable),
        .iMem_ReadData        (iMem_ReadData),
        .oProtocolError       (oProtocolError)
    );

    always @(posedge iClk) begin
        for (int b = 0; b < 4; b++)
            if (oMem_WriteEnable[b]) mem[oMem_Address][8*b +: 8] <= oMem_WriteData[8*b +: 8];
        if (oMem_ReadEnable) iMem_ReadData <= mem[oMem_Address];
    end

    // Outstanding reads = issued minus popped; also watch for illegal strobe combinations.
    always @(negedge iClk) begin
        if (oMem_ReadEnable && (|oMem_WriteEnable)) bothCnt <= bothCnt + 1;
        if (iReset) begin
            if (oMem_ReadEnable || (|oMem_WriteEnable)) rstStrobeCnt <= rstStrobeCnt + 1;
            outst <= 0;
        end else begin
            outst <= outst + int'(oMem_ReadEnable) - int'(oDTL_ReadValid && iDTL_ReadAccept);
            if (outst > maxOut) maxOut <= outst;
        end
    end

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            errCount++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic writeBurst(input logic [31:0] addr, input int bs, input logic [3:0] we,
                              input int lastIdx);
        iDTL_CommandValid     = 1'b1;
        iDTL_CommandReadWrite = 1'b0;
        iDTL_Address          = addr;
        iDTL_BlockSize        = 5'(bs);
        @(negedge iClk);
        checkVal("wr_cmd_accept", 32'(oDTL_CommandAccept), 32'd1);
        @(posedge iClk); #1;
        iDTL_CommandValid = 1'b0;
        for (int i = 0; i <= bs; i++) begin
            iDTL_WriteValid  = 1'b1;
            iDTL_WriteData   = wrBeats[i];
            iDTL_WriteEnable = we;
            iDTL_WriteLast   = (i == lastIdx);
            @(negedge iClk);
            checkVal("wr_beat_accept", 32'(oDTL_WriteAccept), 32'd1);
            @(posedge iClk); #1;
        end
        iDTL_WriteValid = 1'b0;
        iDTL_WriteLast  = 1'b0;
        @(negedge iClk);
        checkVal("wr_done_idle", 32'(oDTL_CommandAccept), 32'd1);
        @(posedge iClk); #1;
    endtask

    // pat[k] drives ReadAccept in cycle t+2+k; 1 afterwards.
    task automatic readBurst(input logic [31:0] addr, input int bs, input logic [15:0] pat,
                             input int patLen);
        int cyc;
        iDTL_CommandValid     = 1'b1;
        iDTL_CommandReadWrite = 1'b1;
        iDTL_Address          = addr;
        iDTL_BlockSize        = 5'(bs);
        @(negedge iClk);
        checkVal("rd_cmd_accept", 32'(oDTL_CommandAccept), 32'd1);
        @(posedge iClk); #1;
        iDTL_CommandValid = 1'b0;
        nGot       = 0;
        firstValid = -1;
        rdLastGot  = '0;
        cyc        = 1;
        while (nGot <= bs && cyc < 100) begin
            if (cyc < 2) iDTL_ReadAccept = 1'b0;
            else if (cyc - 2 < patLen) iDTL_ReadAccept = pat[cyc-2];
            else iDTL_ReadAccept = 1'b1;
            @(negedge iClk);
            if (oDTL_ReadValid && firstValid < 0) firstValid = cyc;
            if (oDTL_ReadValid && iDTL_ReadAccept) begin
                rdGot[nGot]     = oDTL_ReadData;
                rdLastGot[nGot] = oDTL_ReadLast;
                nGot++;
            end
            @(posedge iClk); #1;
            cyc++;
        end
        iDTL_ReadAccept = 1'b0;
        checkVal("rd_beat_count", 32'(nGot), 32'(bs + 1));
        @(negedge iClk);
        checkVal("rd_done_idle", 32'(oDTL_CommandAccept), 32'd1);
        @(posedge iClk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        iReset = 1'b1;
        iDTL_CommandValid = 0; iDTL_CommandReadWrite = 0; iDTL_Address = 0; iDTL_BlockSize = 0;
        iDTL_WriteValid = 0; iDTL_WriteData = 0; iDTL_WriteEnable = 0; iDTL_WriteLast = 0;
        iDTL_ReadAccept = 0;
        @(posedge iClk); #1;
        @(negedge iClk);
        checkVal("rst_cmd_accept_during", 32'(oDTL_CommandAccept), 32'd0);
        @(posedge iClk); #1;
        iReset = 1'b0;
        @(negedge iClk);
        checkVal("rst_cmd_accept_after", 32'(oDTL_CommandAccept), 32'd1);
        checkVal("rst_outputs_zero", {oDTL_WriteAccept, oDTL_ReadValid, oDTL_ReadLast,
                 oMem_ReadEnable, oMem_WriteEnable, oProtocolError}, 32'd0);
        @(posedge iClk); #1;

        // Single write then read with first-beat latency.
        wrBeats[0] = 32'hDEADBEEF;
        writeBurst(32'h10, 0, 4'hF, 0);
        checkVal("single_wr_mem4", mem[4], 32'hDEADBEEF);
        readBurst(32'h10, 0, 16'hFFFF, 16);
        checkVal("single_rd_latency", 32'(firstValid), 32'd2);
        checkVal("single_rd_data", rdGot[0], 32'hDEADBEEF);
        checkVal("single_rd_last", 32'(rdLastGot[0]), 32'd1);

        // Byte enables.
        wrBeats[0] = 32'h11223344;
        writeBurst(32'h10, 0, 4'hF, 0);
        wrBeats[0] = 32'hAABBCCDD;
        writeBurst(32'h10, 0, 4'h5, 0);
        readBurst(32'h10, 0, 16'hFFFF, 16);
        checkVal("byte_en_data", rdGot[0], 32'h11BB33DD);

        // Read burst under back-pressure 1,0,0,1,1,0,1.
        for (int i = 0; i < 4; i++) wrBeats[i] = 32'(i);
        writeBurst(32'h0, 3, 4'hF, 3);
        readBurst(32'h0, 3, 16'h0059, 7);
        for (int i = 0; i < 4; i++) checkVal("bp_rd_data", rdGot[i], 32'(i));
        checkVal("bp_rd_last_flags", 32'(rdLastGot[3:0]), 32'h8);
        checkVal("bp_latency", 32'(firstValid), 32'd2);

        // Address wrap.
        for (int i = 0; i < 3; i++) wrBeats[i] = 32'hA0000000 + 32'(i);
        writeBurst(32'hFF8, 2, 4'hF, 2);
        checkVal("wrap_mem1022", mem[1022], 32'hA0000000);
        checkVal("wrap_mem1023", mem[1023], 32'hA0000001);
        checkVal("wrap_mem0", mem[0], 32'hA0000002);
        checkVal("wrap_no_error", 32'(oProtocolError), 32'd0);

        // Early WriteLast: all beats written, error sticks.
        for (int i = 0; i < 4; i++) wrBeats[i] = 32'h50 + 32'(i);
        writeBurst(32'h40, 3, 4'hF, 1);
        for (int i = 0; i < 4; i++) checkVal("perr_mem", mem[16+i], 32'h50 + 32'(i));
        checkVal("perr_flag", 32'(oProtocolError), 32'd1);
        readBurst(32'h44, 0, 16'hFFFF, 16);
        checkVal("perr_rd_data", rdGot[0], 32'h51);
        @(negedge iClk);
        checkVal("perr_sticky", 32'(oProtocolError), 32'd1);
        @(posedge iClk); #1;

        // Reset on beat 1 of a 4-beat read.
        for (int i = 0; i < 4; i++) wrBeats[i] = 32'hC0 + 32'(i);
        writeBurst(32'h80, 3, 4'hF, 3);
        iDTL_CommandValid = 1'b1; iDTL_CommandReadWrite = 1'b1;
        iDTL_Address = 32'h80; iDTL_BlockSize = 5'd3;
        @(posedge iClk); #1;
        iDTL_CommandValid = 1'b0;
        iDTL_ReadAccept   = 1'b1;
        nGot = 0;
        for (int c = 0; c < 20 && nGot < 1; c++) begin
            @(negedge iClk);
            if (oDTL_ReadValid) begin
                rdGot[0] = oDTL_ReadData;
                nGot++;
            end
            @(posedge iClk); #1;
        end
        checkVal("rstmid_beat0", rdGot[0], 32'hC0);
        iReset = 1'b1;
        @(negedge iClk);
        checkVal("rstmid_rv_during", 32'(oDTL_ReadValid), 32'd0);
        @(posedge iClk); #1;
        iReset = 1'b0;
        iDTL_ReadAccept = 1'b0;
        idleStrobes = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge iClk);
            if (c == 0) begin
                checkVal("rstmid_rv_after", 32'(oDTL_ReadValid), 32'd0);
                checkVal("rstmid_cmd_accept", 32'(oDTL_CommandAccept), 32'd1);
                checkVal("rstmid_err_cleared", 32'(oProtocolError), 32'd0);
            end
            if (oMem_ReadEnable || (|oMem_WriteEnable)) idleStrobes++;
            @(posedge iClk); #1;
        end
        checkVal("rstmid_no_strobes", 32'(idleStrobes), 32'd0);
        wrBeats[0] = 32'h12345678;
        writeBurst(32'h80, 0, 4'hF, 0);
        checkVal("rstmid_new_write", mem[32], 32'h12345678);
        readBurst(32'h80, 1, 16'hFFFF, 16);
        checkVal("rstmid_rd0", rdGot[0], 32'h12345678);
        checkVal("rstmid_rd1", rdGot[1], 32'hC1);

        @(negedge iClk);
        checkVal("never_both_strobes", 32'(bothCnt), 32'd0);
        checkVal("no_strobe_in_reset", 32'(rstStrobeCnt), 32'd0);
        checkVal("max_outstanding_le2", 32'(maxOut <= 2), 32'd1);
        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end
endmodule
